fakeram_req_master: RTL and testbench
=====================================

# fakeram_req_master

Initiator-side controller for the single-port fakeram45 SRAM macros (e.g. the 64x7 instance). It converts a valid/ready request stream into the macro's ce/we/addr/wd/mask port. It absorbs the macro's one-cycle registered read latency and buffers read data against response backpressure. After reset it sweeps the whole array to a known value, so the macro's X-corruption behaviour never leaks into the design.

## Interface
- BITS, 7, data/mask width
- WORD_DEPTH, 64, number of words
- ADDR_WIDTH, 6, address width; WORD_DEPTH == 2**ADDR_WIDTH
- INIT_ON_RESET, 1, 1 = clear array after reset; 0 = ready immediately
- INIT_VALUE, '0, BITS-wide value written during init sweep
- clk  in  1  single clock, all logic on posedge
- reset_n_in  in  1  asynchronous active-low reset
- req_v_in  in  1  request valid
- req_ready_out  out  1  request accepted when req_v_in & req_ready_out
- req_we_in  in  1  1 = masked write, 0 = read
- req_addr_in  in  ADDR_WIDTH  word address
- req_data_in  in  BITS  write data
- req_mask_in  in  BITS  per-bit write enable
- resp_v_out  out  1  read data valid
- resp_data_out  out  BITS  read data
- resp_ready_in  in  1  consumer accepts response
- ram_ce_out  out  1  to macro ce_in
- ram_we_out  out  1  to macro we_in
- ram_addr_out  out  ADDR_WIDTH  to macro addr_in
- ram_wd_out  out  BITS  to macro wd_in
- ram_w_mask_out  out  BITS  to macro w_mask_in
- ram_rd_in  in  BITS  from macro rd_out
- init_done_out  out  1  high once the array is initialised

## Operation
- States: INIT, RUN. Reset enters INIT if INIT_ON_RESET, else RUN.
- INIT: init_cnt runs 0..WORD_DEPTH-1, one word per cycle. Drives ce=1, we=1, addr=init_cnt, wd=INIT_VALUE, mask=all ones. req_ready_out=0. After the last address, go to RUN.
- RUN: req_ready_out = (inflight + fifo_count < 2). This is independent of req_we_in.
- Accepted request: RAM port is driven combinationally in the same cycle: ce=1, we=req_we_in, addr=req_addr_in, wd=req_data_in, mask=req_mask_in.
- Accepted write: produces no response.
- Accepted read: sets inflight for the next cycle.
- Idle cycles: ce=0, we=0, addr=0, wd=0, mask=0. The ram_* outputs are never X while ce=1.
- ram_rd_in is sampled only in a cycle where inflight=1; it is ignored otherwise, since the macro drives X when ce was low.
- Response path:
  - resp_v_out = inflight | (fifo_count != 0).
  - resp_data_out = FIFO head if nonempty, else ram_rd_in (bypass).
  - If inflight and the read is not consumed this cycle, ram_rd_in is enqueued.
- Responses are returned strictly in request order. Write-then-read to the same address in consecutive cycles returns the new data.

## Timing
- Reset values:
  - req_ready_out=0, resp_v_out=0, resp_data_out=0.
  - init_done_out = !INIT_ON_RESET.
  - All ram_* = 0.
  - inflight=0, fifo empty, init_cnt=0.
- Init: in cycle k after reset release (k=0..WORD_DEPTH-1) addr=k is written. init_done_out=1 and req_ready_out may assert from cycle WORD_DEPTH onward.
- Read latency: accepted in cycle t, resp_v_out=1 in cycle t+1 with bypass data.
- Throughput: one request per cycle with resp_ready_in held high.
- Backpressure: at most two reads are outstanding (inflight + FIFO). req_ready_out falls in the cycle the sum reaches 2.
- A FIFO dequeue frees its credit in the next cycle; there is no same-cycle credit return.
- Reset asserted mid-operation: inflight read and FIFO contents are dropped, no response is produced, and the init sweep restarts.

## Structure
- Package fakeram_req_master_pkg: state enum {INIT, RUN} and the credit depth constant (2).
- Sub-module fakeram_resp_fifo: 2-entry, BITS-wide, with enq_v, deq_v, head, count. Its reset is async active-low.

## Test plan
- Init sweep: reset then release. Check 64 writes at addr 0..63 with mask 7'h7F and wd 0. init_done_out rises at cycle 64. A subsequent read of addr 5 returns 0, not X.
- Streaming: 16 back-to-back reads with resp_ready_in=1. Expect 16 responses, each one cycle after acceptance, with req_ready_out never deasserting.
- Masked write: write 7'h55 to addr 3, then write 7'h7F with mask 7'h0F, then read addr 3. Read returns 7'h5F.
- Backpressure: reads to addr 1,2,3 with resp_ready_in=0. Only two are accepted and req_ready_out=0. Release resp_ready_in: responses appear in order 1,2; the third read is then accepted.
- Reset mid-read: assert reset_n_in=0 in the cycle after a read is accepted. No response appears, and after release the init sweep restarts at addr 0.
- INIT_ON_RESET=0: req_ready_out=1 in the first cycle after reset release and the RAM sees no init writes.

Source files
------------

// File: rtl/fakeram_req_master_pkg.sv
// Shared types and constants for the fakeram request master.
package fakeram_req_master_pkg;

  // Controller phases: sweep the array after reset, then serve requests.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Maximum reads that may be outstanding at once (inflight + buffered).
  localparam int unsigned CREDIT_DEPTH = 2;

endpackage : fakeram_req_master_pkg

// File: rtl/fakeram_resp_fifo.sv
// Two-entry response buffer that holds read data while the consumer stalls.
module fakeram_resp_fifo #(
  parameter int BITS = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enq_v,
  input  logic [BITS-1:0] enq_data,
  input  logic            deq_v,
  output logic [BITS-1:0] head,
  output logic [1:0]      count
);

  logic [BITS-1:0] mem_q [2];
  logic [BITS-1:0] mem_d [2];
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q,  count_d;

  // Next-state for pointers, occupancy and storage.
  // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq_v) begin
      mem_d[wr_ptr_q] = enq_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (deq_v) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({enq_v, deq_v})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control registers: pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage.
  // NOTE: storage is not reset; count qualifies every entry, so stale contents are never observed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule : fakeram_resp_fifo

// File: rtl/fakeram_req_master.sv
// Initiator-side controller for a single-port fakeram45 macro: clears the
// array after reset, maps a valid/ready request stream onto the macro port,
// and returns read data in order with two credits of response buffering.
module fakeram_req_master
  import fakeram_req_master_pkg::*;
#(
  parameter int              BITS          = 7,
  parameter int              WORD_DEPTH    = 64,
  parameter int              ADDR_WIDTH    = 6,
  parameter bit              INIT_ON_RESET = 1'b1,
  parameter logic [BITS-1:0] INIT_VALUE    = '0
) (
  input  logic                  clk,
  input  logic                  reset_n_in,
  // Request stream
  input  logic                  req_v_in,
  output logic                  req_ready_out,
  input  logic                  req_we_in,
  input  logic [ADDR_WIDTH-1:0] req_addr_in,
  input  logic [BITS-1:0]       req_data_in,
  input  logic [BITS-1:0]       req_mask_in,
  // Response stream
  output logic                  resp_v_out,
  output logic [BITS-1:0]       resp_data_out,
  input  logic                  resp_ready_in,
  // Macro port
  output logic                  ram_ce_out,
  output logic                  ram_we_out,
  output logic [ADDR_WIDTH-1:0] ram_addr_out,
  output logic [BITS-1:0]       ram_wd_out,
  output logic [BITS-1:0]       ram_w_mask_out,
  input  logic [BITS-1:0]       ram_rd_in,
  // Status
  output logic                  init_done_out
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(WORD_DEPTH - 1);
  localparam state_e                RESET_STATE = INIT_ON_RESET ? ST_INIT : ST_RUN;

  state_e                state_q,    state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  inflight_q, inflight_d;

  logic                  req_fire;
  logic                  resp_fire;
  logic                  fifo_nonempty;
  logic                  fifo_enq_v;
  logic                  fifo_deq_v;
  logic [BITS-1:0]       fifo_head;
  logic [1:0]            fifo_count;
  logic [1:0]            credits_used;

  // State, sweep counter and read-in-flight flag.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= RESET_STATE;
      init_cnt_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  // Next-state: advance the sweep one word per cycle, then track accepted reads.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    inflight_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
        if (init_cnt_q == LAST_ADDR) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end
      end
      ST_RUN: begin
        inflight_d = req_fire & ~req_we_in;
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // Request acceptance: a read credit is free when fewer than two reads are outstanding.
  // The reset input gates the outputs so the macro port and ready stay quiet while reset is held.
  always_comb begin
    credits_used  = fifo_count + {1'b0, inflight_q};
    req_ready_out = reset_n_in && (state_q == ST_RUN) && (credits_used < 2'(CREDIT_DEPTH));
    req_fire      = req_v_in & req_ready_out;
  end

  // Macro port drive: sweep writes during init, pass-through of accepted requests in run.
  always_comb begin
    ram_ce_out     = 1'b0;
    ram_we_out     = 1'b0;
    ram_addr_out   = '0;
    ram_wd_out     = '0;
    ram_w_mask_out = '0;
    if (reset_n_in) begin
      if (state_q == ST_INIT) begin
        ram_ce_out     = 1'b1;
        ram_we_out     = 1'b1;
        ram_addr_out   = init_cnt_q;
        ram_wd_out     = INIT_VALUE;
        ram_w_mask_out = '1;
      end else if (req_fire) begin
        ram_ce_out     = 1'b1;
        ram_we_out     = req_we_in;
        ram_addr_out   = req_addr_in;
        ram_wd_out     = req_data_in;
        ram_w_mask_out = req_mask_in;
      end
    end
  end

  // Response path: FIFO head has priority; otherwise bypass the macro output
  // in the one cycle it carries valid data. Unconsumed macro data is buffered.
  always_comb begin
    fifo_nonempty = (fifo_count != 2'd0);
    resp_v_out    = inflight_q | fifo_nonempty;
    resp_data_out = '0;
    if (fifo_nonempty) begin
      resp_data_out = fifo_head;
    end else if (inflight_q) begin
      resp_data_out = ram_rd_in;
    end
    resp_fire  = resp_v_out & resp_ready_in;
    fifo_deq_v = resp_fire & fifo_nonempty;
    fifo_enq_v = inflight_q & ~(resp_fire & ~fifo_nonempty);
  end

  fakeram_resp_fifo #(
    .BITS (BITS)
  ) u_resp_fifo (
    .clk      (clk),
    .rst_n    (reset_n_in),
    .enq_v    (fifo_enq_v),
    .enq_data (ram_rd_in),
    .deq_v    (fifo_deq_v),
    .head     (fifo_head),
    .count    (fifo_count)
  );

  assign init_done_out = (state_q == ST_RUN);

endmodule : fakeram_req_master

// File: tb/tb_fakeram_req_master.sv
// Self-checking bench for fakeram_req_master: a behavioural macro model,
// a scoreboard of expected read data, a vector table and corner sequences.
module tb_fakeram_req_master;

  localparam int BITS  = 7;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  typedef struct {
    logic            we;
    logic [AW-1:0]   addr;
    logic [BITS-1:0] data;
    logic [BITS-1:0] mask;
    logic [BITS-1:0] exp;
  } vec_t;

  typedef struct {
    logic [BITS-1:0] data;
    int              cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT with init sweep
  logic            req_v, req_ready, req_we, resp_v, resp_ready, init_done;
  logic [AW-1:0]   req_addr, ram_addr;
  logic [BITS-1:0] req_data, req_mask, resp_data, ram_wd, ram_mask, ram_rd;
  logic            ram_ce, ram_we;

  // DUT without init sweep
  logic            req_v0, req_ready0, resp_v0, init_done0, ram_ce0, ram_we0;
  logic [AW-1:0]   ram_addr0;
  logic [BITS-1:0] resp_data0, ram_wd0, ram_mask0;

  fakeram_req_master #(
    .BITS(BITS), .WORD_DEPTH(DEPTH), .ADDR_WIDTH(AW), .INIT_ON_RESET(1'b1), .INIT_VALUE('0)
  ) u_dut (
    .clk(clk), .reset_n_in(reset_n),
    .req_v_in(req_v), .req_ready_out(req_ready), .req_we_in(req_we),
    .req_addr_in(req_addr), .req_data_in(req_data), .req_mask_in(req_mask),
    .resp_v_out(resp_v), .resp_data_out(resp_data), .resp_ready_in(resp_ready),
    .ram_ce_out(ram_ce), .ram_we_out(ram_we), .ram_addr_out(ram_addr),
    .ram_wd_out(ram_wd), .ram_w_mask_out(ram_mask), .ram_rd_in(ram_rd),
    .init_done_out(init_done)
  );

  fakeram_req_master #(
    .BITS(BITS), .WORD_DEPTH(DEPTH), .ADDR_WIDTH(AW), .INIT_ON_RESET(1'b0), .INIT_VALUE('0)
  ) u_dut_noinit (
    .clk(clk), .reset_n_in(reset_n),
    .req_v_in(req_v0), .req_ready_out(req_ready0), .req_we_in(1'b0),
    .req_addr_in('0), .req_data_in('0), .req_mask_in('0),
    .resp_v_out(resp_v0), .resp_data_out(resp_data0), .resp_ready_in(1'b1),
    .ram_ce_out(ram_ce0), .ram_we_out(ram_we0), .ram_addr_out(ram_addr0),
    .ram_wd_out(ram_wd0), .ram_w_mask_out(ram_mask0), .ram_rd_in('0),
    .init_done_out(init_done0)
  );

  // Behavioural macro: one-cycle registered read, junk output when not reading.
  logic [BITS-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = 7'h33;
  always @(posedge clk) begin
    if (ram_ce && ram_we) begin
      mem[ram_addr] <= (mem[ram_addr] & ~ram_mask) | (ram_wd & ram_mask);
      ram_rd <= '1;
    end else if (ram_ce) begin
      ram_rd <= mem[ram_addr];
    end else begin
      ram_rd <= '1;
    end
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_resp   = 0;
  bit   lat_mode = 1'b0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one request, waiting (bounded) for acceptance; reads push their expectation.
  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [BITS-1:0] data,
                        input logic [BITS-1:0] mask, input logic [BITS-1:0] exp, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    req_v = 1'b1; req_we = we; req_addr = addr; req_data = data; req_mask = mask;
    while (!done) begin
      @(negedge clk);
      if (req_ready) begin
        done = 1'b1;
        if (!we) exp_q.push_back('{data: exp, cyc: cyc});
      end else begin
        waits++;
      end
      @(posedge clk); #1;
      if (!done && waits > 50) begin
        check("req_timeout", 32'(waits), 32'd0);
        done = 1'b1;
      end
    end
    req_v = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Response monitor: pops the scoreboard on every handshake.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && resp_v && resp_ready) begin
        n_resp++;
        check("resp_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("resp_data", 32'(resp_data), 32'(e.data));
          if (lat_mode) check("resp_latency", 32'(cyc), 32'(e.cyc + 1));
        end
      end
    end
  endtask

  vec_t tbl[12];

  initial begin
    int              waits;
    int              w;
    int              resp_before;
    bit              ce0_seen;
    logic [BITS-1:0] d;

    tbl[0]  = '{we: 1'b1, addr: 6'd3,  data: 7'h55, mask: 7'h7F, exp: 7'h00};
    tbl[1]  = '{we: 1'b1, addr: 6'd3,  data: 7'h7F, mask: 7'h0F, exp: 7'h00};
    tbl[2]  = '{we: 1'b0, addr: 6'd3,  data: 7'h00, mask: 7'h00, exp: 7'h5F};
    tbl[3]  = '{we: 1'b1, addr: 6'd10, data: 7'h2A, mask: 7'h7F, exp: 7'h00};
    tbl[4]  = '{we: 1'b0, addr: 6'd10, data: 7'h00, mask: 7'h00, exp: 7'h2A};
    tbl[5]  = '{we: 1'b1, addr: 6'd10, data: 7'h00, mask: 7'h70, exp: 7'h00};
    tbl[6]  = '{we: 1'b0, addr: 6'd10, data: 7'h00, mask: 7'h00, exp: 7'h0A};
    tbl[7]  = '{we: 1'b1, addr: 6'd63, data: 7'h7F, mask: 7'h7F, exp: 7'h00};
    tbl[8]  = '{we: 1'b0, addr: 6'd63, data: 7'h00, mask: 7'h00, exp: 7'h7F};
    tbl[9]  = '{we: 1'b0, addr: 6'd0,  data: 7'h00, mask: 7'h00, exp: 7'h00};
    tbl[10] = '{we: 1'b1, addr: 6'd0,  data: 7'h12, mask: 7'h00, exp: 7'h00};
    tbl[11] = '{we: 1'b0, addr: 6'd0,  data: 7'h00, mask: 7'h00, exp: 7'h00};

    req_v = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0; req_mask = '0;
    resp_ready = 1'b1; req_v0 = 1'b0;

    fork
      monitor();
    join_none

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_resp", 32'({resp_v, resp_data}), 32'd0);
    check("rst_ram", 32'({ram_ce, ram_we, ram_addr, ram_wd, ram_mask}), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_noinit", 32'({init_done0, req_ready0, ram_ce0}), 32'b100);

    // Init sweep
    @(posedge clk); #1;
    reset_n = 1'b1;
    ce0_seen = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      check("init_wr", 32'({ram_ce, ram_we, ram_addr, ram_wd, ram_mask, req_ready, init_done}),
            32'({1'b1, 1'b1, 6'(k), 7'h00, 7'h7F, 1'b0, 1'b0}));
      if (k == 0) check("noinit_ready", 32'({req_ready0, init_done0}), 32'b11);
      if (ram_ce0) ce0_seen = 1'b1;
    end
    @(negedge clk);
    check("init_done", 32'({init_done, req_ready}), 32'b11);
    check("noinit_no_writes", 32'(ce0_seen), 32'd0);
    @(posedge clk); #1;

    // Cleared array reads back the init value
    do_req(1'b0, 6'd5, '0, '0, 7'h00, waits);
    drain();

    // Vector table
    for (int i = 0; i < 12; i++)
      do_req(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].mask, tbl[i].exp, waits);
    drain();

    // Streaming: preload, then 16 back-to-back reads
    for (int i = 0; i < 16; i++) begin
      d = 7'(i * 5 + 3);
      do_req(1'b1, 6'(20 + i), d, 7'h7F, 7'h00, waits);
    end
    drain();
    lat_mode    = 1'b1;
    resp_before = n_resp;
    for (int i = 0; i < 16; i++) begin
      d = 7'(i * 5 + 3);
      do_req(1'b0, 6'(20 + i), '0, '0, d, waits);
      check("stream_ready", 32'(waits), 32'd0);
    end
    drain();
    lat_mode = 1'b0;
    check("stream_count", 32'(n_resp - resp_before), 32'd16);

    // Backpressure
    do_req(1'b1, 6'd1, 7'h11, 7'h7F, 7'h00, waits);
    do_req(1'b1, 6'd2, 7'h22, 7'h7F, 7'h00, waits);
    do_req(1'b1, 6'd3, 7'h33, 7'h7F, 7'h00, waits);
    resp_ready = 1'b0;
    req_v = 1'b1; req_we = 1'b0; req_addr = 6'd1;
    @(negedge clk);
    check("bp_rdy1", 32'(req_ready), 32'd1);
    if (req_ready) exp_q.push_back('{data: 7'h11, cyc: cyc});
    @(posedge clk); #1;
    req_addr = 6'd2;
    @(negedge clk);
    check("bp_rdy2", 32'(req_ready), 32'd1);
    if (req_ready) exp_q.push_back('{data: 7'h22, cyc: cyc});
    @(posedge clk); #1;
    req_addr = 6'd3;
    @(negedge clk);
    check("bp_full", 32'(req_ready), 32'd0);
    check("bp_head", 32'({resp_v, resp_data}), 32'({1'b1, 7'h11}));
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_full2", 32'({req_ready, resp_v, resp_data}), 32'({1'b0, 1'b1, 7'h11}));
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_no_same_cycle_credit", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_third", 32'(req_ready), 32'd1);
    if (req_ready) exp_q.push_back('{data: 7'h33, cyc: cyc});
    @(posedge clk); #1;
    req_v = 1'b0;
    drain();

    // Reset in the cycle after a read is accepted
    do_req(1'b0, 6'd3, '0, '0, 7'h33, waits);
    reset_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_quiet", 32'({resp_v, req_ready, ram_ce}), 32'd0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("reinit_addr0", 32'({ram_ce, ram_we, ram_addr, resp_v}), 32'({1'b1, 1'b1, 6'd0, 1'b0}));
    w = 0;
    while (!init_done && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("reinit_cycles", 32'(w), 32'd64);
    @(posedge clk); #1;
    do_req(1'b0, 6'd3, '0, '0, 7'h00, waits);
    drain();

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fakeram_req_master
